// File: rtl/prog_counter_if.sv
// ==== prog_counter_if : control/status bundle for prog_counter -- rev 1.0 ====
`default_nettype none

interface prog_counter_if #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
);
  logic               en;
  logic               dir;
  logic [1:0]         mode;
  logic [PRESC_W-1:0] presc;
  logic               load;
  logic [WIDTH-1:0]   load_val;
  logic [WIDTH-1:0]   limit;
  logic [WIDTH-1:0]   cmp_val;
  logic [WIDTH-1:0]   count;
  logic               tc;
  logic               cmp_match;
  logic               running;
  logic               oe;

  modport master (
    output en, dir, mode, presc, load, load_val, limit, cmp_val,
    input  count, tc, cmp_match, running, oe
  );

  modport slave (
    input  en, dir, mode, presc, load, load_val, limit, cmp_val,
    output count, tc, cmp_match, running, oe
  );
endinterface

`default_nettype wire

// File: rtl/prog_counter.sv
// ==== prog_counter : prescaled up/down counter, wrap/saturate/one-shot -- rev 1.0 ====
`default_nettype none

module prog_counter #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
) (
  input  wire logic  clk,
  input  wire logic  rst,
  prog_counter_if.slave bus
);
  localparam logic [1:0] C_MODE_SAT     = 2'b01;
  localparam logic [1:0] C_MODE_ONESHOT = 2'b10;

  logic [WIDTH-1:0]   count_q, count_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic               tc_q, tc_d;
  logic               running_q, running_d;

  logic               w_tick;
  logic               w_at_term;
  logic               w_arrive;
  logic [WIDTH-1:0]   w_step;
  logic [WIDTH-1:0]   w_term;

  always_comb begin
    w_tick    = bus.en && !bus.load && (pcnt_q == bus.presc);
    w_term    = bus.dir ? '0 : bus.limit;
    // ">=" catches a count left above limit by a load or a limit change
    w_at_term = bus.dir ? (count_q == '0) : (count_q >= bus.limit);
    w_step    = bus.dir ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
    w_arrive  = (w_step == w_term);

    pcnt_d = pcnt_q;
    if (bus.load) begin
      pcnt_d = '0;
    end else if (bus.en) begin
      pcnt_d = (pcnt_q == bus.presc) ? '0 : (pcnt_q + PRESC_W'(1));
    end

    count_d   = count_q;
    tc_d      = 1'b0;
    running_d = running_q;
    if (bus.load) begin
      count_d   = bus.load_val;
      running_d = 1'b1;
    end else if (w_tick && running_q) begin
      if (w_at_term) begin
        if (bus.mode != C_MODE_SAT && bus.mode != C_MODE_ONESHOT) begin
          count_d = bus.dir ? bus.limit : '0;
          tc_d    = ~tc_q;
        end
      end else begin
        count_d = w_step;
        if (w_arrive && bus.mode == C_MODE_SAT) begin
          tc_d = ~tc_q;
        end else if (w_arrive && bus.mode == C_MODE_ONESHOT) begin
          tc_d      = ~tc_q;
          running_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      pcnt_q    <= '0;
      tc_q      <= 1'b0;
      running_q <= 1'b1;
    end else begin
      count_q   <= count_d;
      pcnt_q    <= pcnt_d;
      tc_q      <= tc_d;
      running_q <= running_d;
    end
  end

  assign bus.count     = count_q;
  assign bus.tc        = tc_q;
  assign bus.running   = running_q;
  assign bus.cmp_match = (count_q == bus.cmp_val);
  assign bus.oe        = bus.en && running_q && (count_q != w_term);
endmodule

`default_nettype wire

// File: tb/tb_prog_counter.sv
// ==== tb_prog_counter : directed self-checking bench for prog_counter -- rev 1.0 ====
`default_nettype none

module tb_prog_counter;
  localparam int WIDTH   = 8;
  localparam int PRESC_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  prog_counter_if #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) bus ();

  prog_counter #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b0; bus.dir = 1'b0; bus.mode = 2'b00; bus.presc = '0;
    bus.load = 1'b0; bus.load_val = '0; bus.limit = 8'd255; bus.cmp_val = 8'd3;
    step(); step();
    rst = 1'b0;
    tests++; if (bus.count !== 8'd0) begin fails++; $display("FAIL reset_count got %0d want 0", bus.count); end
    tests++; if (bus.tc !== 1'b0) begin fails++; $display("FAIL reset_tc got %b want 0", bus.tc); end
    tests++; if (bus.running !== 1'b1) begin fails++; $display("FAIL reset_running got %b want 1", bus.running); end
    step();
    tests++; if (bus.count !== 8'd0) begin fails++; $display("FAIL reset_hold_en0 got %0d want 0", bus.count); end
  endtask

  task automatic test_legacy();
    logic [7:0] exp;
    exp = 8'd0;
    bus.en = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      step();
      exp = exp + 8'd1;
      tests++; if (bus.count !== exp) begin fails++; $display("FAIL legacy_count k=%0d got %0d want %0d", k, bus.count, exp); end
      tests++; if (bus.tc !== (exp == 8'd0)) begin fails++; $display("FAIL legacy_tc k=%0d got %b want %b", k, bus.tc, exp == 8'd0); end
      tests++; if (bus.oe !== (exp != 8'd255)) begin fails++; $display("FAIL legacy_oe k=%0d got %b want %b", k, bus.oe, exp != 8'd255); end
    end
  endtask

  task automatic check_presc(input int k);
    int ec;
    logic et;
    ec = (k / 3) % 6;
    et = (k % 3 == 0) && (ec == 0);
    tests++; if (bus.count !== 8'(ec)) begin fails++; $display("FAIL presc_count k=%0d got %0d want %0d", k, bus.count, ec); end
    tests++; if (bus.tc !== et) begin fails++; $display("FAIL presc_tc k=%0d got %b want %b", k, bus.tc, et); end
  endtask

  task automatic test_prescale();
    bus.presc = 4'd2; bus.limit = 8'd5; bus.dir = 1'b0; bus.mode = 2'b00;
    bus.load_val = 8'd0; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    for (int k = 1; k <= 36; k++) begin step(); check_presc(k); end
    bus.en = 1'b0;
    for (int h = 0; h < 4; h++) begin
      step();
      tests++; if (bus.count !== 8'd0 || bus.tc !== 1'b0) begin
        fails++; $display("FAIL presc_freeze h=%0d got count=%0d tc=%b want 0/0", h, bus.count, bus.tc);
      end
    end
    bus.en = 1'b1;
    for (int k = 37; k <= 42; k++) begin step(); check_presc(k); end
  endtask

  task automatic test_down_sat();
    logic [7:0] ec [5] = '{8'd2, 8'd1, 8'd0, 8'd0, 8'd0};
    logic       et [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    bus.presc = '0; bus.dir = 1'b1; bus.mode = 2'b01;
    bus.load_val = 8'd3; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    tests++; if (bus.count !== 8'd3) begin fails++; $display("FAIL dsat_load got %0d want 3", bus.count); end
    for (int i = 0; i < 5; i++) begin
      step();
      tests++; if (bus.count !== ec[i]) begin fails++; $display("FAIL dsat_count i=%0d got %0d want %0d", i, bus.count, ec[i]); end
      tests++; if (bus.tc !== et[i]) begin fails++; $display("FAIL dsat_tc i=%0d got %b want %b", i, bus.tc, et[i]); end
      tests++; if (bus.running !== 1'b1) begin fails++; $display("FAIL dsat_running i=%0d got %b want 1", i, bus.running); end
      tests++; if (bus.oe !== (ec[i] != 8'd0)) begin fails++; $display("FAIL dsat_oe i=%0d got %b want %b", i, bus.oe, ec[i] != 8'd0); end
    end
  endtask

  task automatic test_oneshot();
    logic [7:0] ec [7] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd4, 8'd4, 8'd4};
    logic       et [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       er [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    bus.dir = 1'b0; bus.mode = 2'b10; bus.limit = 8'd4;
    bus.load_val = 8'd0; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      tests++; if (bus.count !== ec[i]) begin fails++; $display("FAIL os_count i=%0d got %0d want %0d", i, bus.count, ec[i]); end
      tests++; if (bus.tc !== et[i]) begin fails++; $display("FAIL os_tc i=%0d got %b want %b", i, bus.tc, et[i]); end
      tests++; if (bus.running !== er[i]) begin fails++; $display("FAIL os_running i=%0d got %b want %b", i, bus.running, er[i]); end
    end
    tests++; if (bus.oe !== 1'b0) begin fails++; $display("FAIL os_oe got %b want 0", bus.oe); end
    bus.load_val = 8'd1; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    tests++; if (bus.count !== 8'd1 || bus.running !== 1'b1 || bus.tc !== 1'b0) begin
      fails++; $display("FAIL os_reload got count=%0d run=%b tc=%b want 1/1/0", bus.count, bus.running, bus.tc);
    end
    step();
    tests++; if (bus.count !== 8'd2) begin fails++; $display("FAIL os_resume got %0d want 2", bus.count); end
  endtask

  task automatic test_boundary();
    bus.mode = 2'b00; bus.limit = 8'd10; bus.dir = 1'b0;
    bus.load_val = 8'd200; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    tests++; if (bus.count !== 8'd200) begin fails++; $display("FAIL bnd_load got %0d want 200", bus.count); end
    step();
    tests++; if (bus.count !== 8'd0 || bus.tc !== 1'b1) begin
      fails++; $display("FAIL bnd_wrap got count=%0d tc=%b want 0/1", bus.count, bus.tc);
    end
    step();
    tests++; if (bus.count !== 8'd1 || bus.tc !== 1'b0) begin
      fails++; $display("FAIL bnd_after got count=%0d tc=%b want 1/0", bus.count, bus.tc);
    end
    rst = 1'b1; bus.load = 1'b1; bus.load_val = 8'd77;
    step();
    rst = 1'b0; bus.load = 1'b0;
    tests++; if (bus.count !== 8'd0 || bus.running !== 1'b1) begin
      fails++; $display("FAIL bnd_rst_load got count=%0d run=%b want 0/1", bus.count, bus.running);
    end
  endtask

  task automatic test_compare();
    logic [7:0] exp;
    exp = 8'd0;
    bus.cmp_val = 8'd3;
    tests++; if (bus.cmp_match !== 1'b0) begin fails++; $display("FAIL cmp c=0 got %b want 0", bus.cmp_match); end
    for (int i = 0; i < 6; i++) begin
      step();
      exp = exp + 8'd1;
      tests++; if (bus.count !== exp) begin fails++; $display("FAIL cmp_count got %0d want %0d", bus.count, exp); end
      tests++; if (bus.cmp_match !== (exp == 8'd3)) begin
        fails++; $display("FAIL cmp c=%0d got %b want %b", exp, bus.cmp_match, exp == 8'd3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_legacy();
    test_prescale();
    test_down_sat();
    test_oneshot();
    test_boundary();
    test_compare();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

`default_nettype wire
